// File: rtl/fuel_tank_ctrl_pkg.sv
// fuel_pkg: shared types and constants for the fuel tank controller.
//   state_t : controller state enum {IDLE, RUN, EMPTY}
//   fuel_t  : fuel level word, FUEL_W bits wide
//   is_low(): low-fuel predicate used for the registered fuelLow flag
package fuel_pkg;

   localparam int FUEL_MAX     = 100;
   localparam int FUEL_W       = 7;
   localparam int DRAIN_DIV    = 30;
   localparam int REFILL_AMT   = 25;
   localparam int HIT_PENALTY  = 10;
   localparam int LOW_THRESH   = 20;
   localparam int FLASH_FRAMES = 15;

   // Accumulator never exceeds (DRAIN_DIV-1) + 15 = 44 before subtraction.
   localparam int ACC_W        = 6;
   localparam int FLASH_W      = 4;

   typedef logic [FUEL_W-1:0] fuel_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      EMPTY = 2'd2
   } state_t;

   function automatic logic is_low(fuel_t lvl);
      return (lvl <= fuel_t'(LOW_THRESH)) && (lvl != '0);
   endfunction

endpackage

// File: rtl/fuel_tank_ctrl_if.sv
// fuel_tank_ctrl_if: frame events and HUD/status outputs of the fuel tank
// controller.
//   master : drives startOfFrame, gameActive, speed, fuelHitPulse, carHitPulse
//   slave  : drives fuelLevel, fuelLow, fuelEmpty, gameOverReq, refuelFlash
interface fuel_tank_ctrl_if;
   import fuel_pkg::*;

   logic       startOfFrame;
   logic       gameActive;
   logic [3:0] speed;
   logic       fuelHitPulse;
   logic       carHitPulse;
   fuel_t      fuelLevel;
   logic       fuelLow;
   logic       fuelEmpty;
   logic       gameOverReq;
   logic       refuelFlash;

   modport master (
      output startOfFrame, gameActive, speed, fuelHitPulse, carHitPulse,
      input  fuelLevel, fuelLow, fuelEmpty, gameOverReq, refuelFlash
   );

   modport slave (
      input  startOfFrame, gameActive, speed, fuelHitPulse, carHitPulse,
      output fuelLevel, fuelLow, fuelEmpty, gameOverReq, refuelFlash
   );

endinterface

// File: rtl/fuel_drain_accum.sv
// fuel_drain_accum: accumulates player speed once per frame and strobes
// drain for one cycle when DRAIN_DIV speed-units have built up.
//   clk, reset   : clock, synchronous active-high reset
//   clr          : hold accumulator at zero
//   en           : accumulate on startOfFrame only while enabled
//   startOfFrame : frame strobe
//   speed        : player speed 0..15
//   drain        : combinational strobe, valid in the startOfFrame cycle
module fuel_drain_accum
   import fuel_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       en,
   input  logic       startOfFrame,
   input  logic [3:0] speed,
   output logic       drain
);

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_sum;

   assign acc_sum = acc_q + ACC_W'(speed);
   // Speed <= 15 < DRAIN_DIV, so one subtraction always suffices.
   assign drain   = en && startOfFrame && (acc_sum >= ACC_W'(DRAIN_DIV));

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         acc_q <= '0;
      end else if (en && startOfFrame) begin
         acc_q <= drain ? (acc_sum - ACC_W'(DRAIN_DIV)) : acc_sum;
      end
   end

endmodule

// File: rtl/fuel_tank_ctrl.sv
// fuel_tank_ctrl: per-frame fuel bookkeeping for the player car.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fuel_tank_ctrl_if.slave (frame events in, HUD/status out)
// Optional macro FUEL_TANK_FLASH_EN adds a refuel flash frame counter;
// without it refuelFlash is tied low.
//
// state | meaning
// IDLE  | no round running, level held, waiting for gameActive
// RUN   | round running: drain, refill and hit penalty applied
// EMPTY | tank ran dry, gameOverReq held until gameActive drops
module fuel_tank_ctrl
   import fuel_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   fuel_tank_ctrl_if.slave   bus
);

   typedef logic signed [FUEL_W+1:0] sum_t;

   state_t state_q;
   fuel_t  level_q;
   logic   low_q;
   logic   empty_q;
   logic   gor_q;
   logic   fuel_seen_q;
   logic   car_seen_q;

   logic   drain;
   logic   fuel_acc;
   logic   car_acc;
   sum_t   sum_s;
   fuel_t  run_level;

   fuel_drain_accum u_drain (
      .clk          (clk),
      .reset        (reset),
      .clr          (state_q == IDLE),
      .en           (state_q == RUN),
      .startOfFrame (bus.startOfFrame),
      .speed        (bus.speed),
      .drain        (drain)
   );

   // startOfFrame opens a new frame, so a pulse in that very cycle is
   // accepted even if the same type was taken in the previous frame.
   always_comb begin
      fuel_acc = (state_q == RUN) && bus.fuelHitPulse
                 && (!fuel_seen_q || bus.startOfFrame);
      car_acc  = (state_q == RUN) && bus.carHitPulse
                 && (!car_seen_q || bus.startOfFrame);

      sum_s = sum_t'({2'b00, level_q});
      if (fuel_acc) sum_s = sum_s + sum_t'(REFILL_AMT);
      if (car_acc)  sum_s = sum_s - sum_t'(HIT_PENALTY);
      if (drain)    sum_s = sum_s - sum_t'(1);

      if (sum_s < 0)
         run_level = '0;
      else if (sum_s > sum_t'(FUEL_MAX))
         run_level = fuel_t'(FUEL_MAX);
      else
         run_level = fuel_t'(sum_s);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         level_q     <= fuel_t'(FUEL_MAX);
         low_q       <= 1'b0;
         empty_q     <= 1'b0;
         gor_q       <= 1'b0;
         fuel_seen_q <= 1'b0;
         car_seen_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               fuel_seen_q <= 1'b0;
               car_seen_q  <= 1'b0;
               if (bus.gameActive) begin
                  state_q <= RUN;
                  level_q <= fuel_t'(FUEL_MAX);
                  low_q   <= is_low(fuel_t'(FUEL_MAX));
                  empty_q <= 1'b0;
               end else begin
                  low_q   <= is_low(level_q);
                  empty_q <= (level_q == '0);
               end
            end
            RUN: begin
               if (!bus.gameActive) begin
                  state_q     <= IDLE;
                  gor_q       <= 1'b0;
                  low_q       <= is_low(level_q);
                  empty_q     <= (level_q == '0);
                  fuel_seen_q <= 1'b0;
                  car_seen_q  <= 1'b0;
               end else begin
                  level_q     <= run_level;
                  low_q       <= is_low(run_level);
                  empty_q     <= (run_level == '0);
                  fuel_seen_q <= fuel_acc ? 1'b1 : (bus.startOfFrame ? 1'b0 : fuel_seen_q);
                  car_seen_q  <= car_acc  ? 1'b1 : (bus.startOfFrame ? 1'b0 : car_seen_q);
                  if (run_level == '0) begin
                     state_q <= EMPTY;
                     gor_q   <= 1'b1;
                  end
               end
            end
            EMPTY: begin
               low_q   <= is_low(level_q);
               empty_q <= (level_q == '0);
               if (!bus.gameActive) begin
                  state_q <= IDLE;
                  gor_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               gor_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.fuelLevel   = level_q;
   assign bus.fuelLow     = low_q;
   assign bus.fuelEmpty   = empty_q;
   assign bus.gameOverReq = gor_q;

`ifdef FUEL_TANK_FLASH_EN
   logic [FLASH_W-1:0] flash_q;

   // Cleared while idle and on any exit to IDLE; a refill reloads it.
   always_ff @(posedge clk) begin
      if (reset) begin
         flash_q <= '0;
      end else if ((state_q == IDLE) || !bus.gameActive) begin
         flash_q <= '0;
      end else if (fuel_acc) begin
         flash_q <= FLASH_W'(FLASH_FRAMES);
      end else if (bus.startOfFrame && (flash_q != '0)) begin
         flash_q <= flash_q - 1'b1;
      end
   end

   assign bus.refuelFlash = (flash_q != '0);
`else
   assign bus.refuelFlash = 1'b0;
`endif

endmodule

// File: doc/fuel_tank_ctrl.md
Name: fuel_tank_ctrl

Overview:
- Consumes the once-per-frame fuel-pickup and car-hit pulses from the collision/fuel mux and maintains the player's fuel level.
- Drains fuel each frame in proportion to player speed, refills on pickup, and applies a penalty on car collision.
- Drives the HUD fuel-bar level, a low-fuel warning and the game-over request to the game controller.

Parameters:
- FUEL_MAX, 100, full-tank level; also the value loaded at game start.
- FUEL_W, 7, width of the fuel level; must hold FUEL_MAX.
- DRAIN_DIV, 30, speed-units accumulated per 1 unit of fuel drained.
- REFILL_AMT, 25, units added per fuel pickup.
- HIT_PENALTY, 10, units removed per car hit.
- LOW_THRESH, 20, fuelLow asserted when level <= LOW_THRESH.
- FLASH_FRAMES, 15, refuel flash duration in frames (optional feature only).

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous reset, active-high.
- startOfFrame, in, 1, one-cycle pulse at the start of each frame (30 Hz).
- gameActive, in, 1, high while a game round is running.
- speed, in, 4, current player speed, 0..15.
- fuelHitPulse, in, 1, single pulse per frame on player/fuel overlap.
- carHitPulse, in, 1, single pulse per frame on player/car collision.
- fuelLevel, out, FUEL_W, current fuel, 0..FUEL_MAX.
- fuelLow, out, 1, level <= LOW_THRESH and level > 0.
- fuelEmpty, out, 1, level == 0.
- gameOverReq, out, 1, sticky request to the game controller.
- refuelFlash, out, 1, HUD flash enable.

Behaviour:
- Clocking: single clock domain; reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset state:
  - state = IDLE, fuelLevel = FUEL_MAX, accumulator = 0.
  - fuelLow = 0, fuelEmpty = 0, gameOverReq = 0, refuelFlash = 0.
  - A reset mid-operation overrides every other input in that cycle.
- State machine:
  - IDLE -> RUN when gameActive = 1. On that edge fuelLevel reloads to FUEL_MAX and the accumulator clears.
  - RUN -> EMPTY when the updated level = 0.
  - RUN or EMPTY -> IDLE when gameActive = 0; gameOverReq clears.
  - EMPTY is terminal for the round: gameOverReq = 1 from the first cycle in EMPTY; pickups and hits are ignored.
- Drain (RUN only, evaluated on the startOfFrame cycle):
  - acc_next = acc + speed.
  - If acc_next >= DRAIN_DIV: acc <= acc_next - DRAIN_DIV and drain = 1.
  - Otherwise acc <= acc_next and drain = 0.
  - At most 1 unit drained per frame.
- Pickup and hit pulses (RUN only):
  - Refill saturates at FUEL_MAX.
  - Penalty saturates at 0.
  - Each pulse type is accepted at most once per frame; a per-type flag is set on acceptance and cleared on startOfFrame.
- Simultaneous events in one cycle are combined in a fixed order: level + refill - penalty - drain.
  - Intermediate width is FUEL_W+2, signed.
  - The result is clamped to [0, FUEL_MAX].
- Latency: outputs are registered and reflect an event one cycle after the event cycle.
- Status flags: fuelLow and fuelEmpty are registered and derived from the next-state level.

Optional Feature:
- Macro: FUEL_TANK_FLASH_EN.
- Defined:
  - An accepted refill loads a frame counter with FLASH_FRAMES.
  - refuelFlash = 1 while the counter > 0; the counter decrements on startOfFrame.
  - A new refill during a flash reloads the counter.
  - The counter clears on reset and on entering IDLE.
- Undefined: refuelFlash is tied to 0 and no counter exists.

Decomposition:
- Shared package fuel_pkg holds:
  - the state enum {IDLE, RUN, EMPTY};
  - the localparam FUEL_W;
  - the typedef fuel_t = logic [FUEL_W-1:0].
- One sub-module, fuel_drain_accum: speed accumulator plus the drain strobe. Inputs: clk, reset, clr, en, startOfFrame, speed. Output: drain.

Test Plan:
- Reset, then gameActive=1, speed=0 for 100 frames -> fuelLevel stays 100, fuelEmpty=0.
- speed=15, DRAIN_DIV=30 -> exactly 1 unit drained every 2 frames; 10 frames -> fuelLevel = 95.
- Level 90, fuelHitPulse -> 100 (saturated). A second pulse in the same frame -> ignored.
- Level 5, carHitPulse -> 0 one cycle later; fuelEmpty=1, gameOverReq=1, state EMPTY. A subsequent fuelHitPulse -> level stays 0.
- Level 30, fuelHitPulse + carHitPulse + drain strobe in the same cycle -> 30+25-10-1 = 44.
- In EMPTY with gameOverReq=1: deassert gameActive -> IDLE, gameOverReq=0. Then assert reset mid-frame -> all outputs at reset values on the next edge.
